// File: rtl/ddr4_cmd_issuer.sv
// rtl/ddr4_cmd_issuer.sv - single-request DDR4 command issuer, closed-page (ACT, RD/WR, PRE)
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_we/...    one request at a time; fields captured on acceptance
//   cke, cs_n, act_n, A, bg, ba       registered DIMM command bus
//   dq_o, dq_oe, dq_i                 registered write data / enable, read data input
//   stall                             defers command-issue cycles only
//   rd_data, rd_valid, busy           read beats and activity status
module ddr4_cmd_issuer #(
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int DQWIDTH   = 64,
    parameter int BL        = 8,
    parameter int tRCD      = 3,
    parameter int tCL       = 4,
    parameter int tCWL      = 3,
    parameter int tRP       = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    input  logic [DQWIDTH-1:0]   req_wdata,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic [DQWIDTH-1:0]   dq_o,
    output logic                 dq_oe,
    input  logic [DQWIDTH-1:0]   dq_i,
    input  logic                 stall,
    output logic [DQWIDTH-1:0]   rd_data,
    output logic                 rd_valid,
    output logic                 busy
);

    localparam int MAX_A = (tRCD > tRP) ? tRCD : tRP;
    localparam int MAX_B = (tCL > tCWL) ? (tCL + BL) : (tCWL + BL);
    localparam int MAX_L = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_L + 1);

    typedef enum logic [2:0] {IDLE, ACT, TRCD, CAS, LAT, DATA, PRE, TRP} state_t;

    state_t                 state, state_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic                   capture;
    logic                   cap_we;
    logic [BGWIDTH-1:0]     cap_bg;
    logic [BAWIDTH-1:0]     cap_ba;
    logic [ADDRWIDTH-1:0]   cap_row;
    logic [COLWIDTH-1:0]    cap_col;
    logic [DQWIDTH-1:0]     cap_wdata;
    logic                   cs_n_d, act_n_d, dq_oe_d, smp_v_d;
    logic [ADDRWIDTH-1:0]   a_d, a_cas, a_pre;
    logic [BGWIDTH-1:0]     bg_d;
    logic [BAWIDTH-1:0]     ba_d;
    logic [DQWIDTH-1:0]     dq_o_d;
    // Read beats pass through one sample stage so rd_valid trails the dq_i sample by a cycle.
    logic                   smp_v;
    logic [DQWIDTH-1:0]     smp_d;

    assign req_ready = (state == IDLE) && cke;
    assign busy      = !req_ready;

    always_comb begin
        a_cas = '0;
        a_cas[COLWIDTH-1:0] = cap_col;
        a_cas[10] = 1'b0;
        a_cas[16:14] = cap_we ? 3'b100 : 3'b101;
        a_pre = '0;
        a_pre[16:14] = 3'b010;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        cs_n_d  = 1'b1;
        act_n_d = 1'b1;
        a_d     = A;
        bg_d    = bg;
        ba_d    = ba;
        dq_oe_d = 1'b0;
        dq_o_d  = '0;
        smp_v_d = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && cke) begin
                    capture = 1'b1;
                    state_d = ACT;
                end
            end
            ACT: begin
                if (!stall) begin
                    cs_n_d  = 1'b0;
                    act_n_d = 1'b0;
                    a_d     = cap_row;
                    bg_d    = cap_bg;
                    ba_d    = cap_ba;
                    if (tRCD > 1) begin
                        state_d = TRCD;
                        cnt_d   = CW'(tRCD - 2);
                    end else begin
                        state_d = CAS;
                    end
                end
            end
            TRCD: begin
                if (cnt == '0) state_d = CAS;
                else           cnt_d   = cnt - CW'(1);
            end
            CAS: begin
                if (!stall) begin
                    cs_n_d = 1'b0;
                    a_d    = a_cas;
                    // LAT covers the latency minus the CAS cycle and the first beat cycle.
                    if (cap_we ? (tCWL > 1) : (tCL > 1)) begin
                        state_d = LAT;
                        cnt_d   = cap_we ? CW'(tCWL - 2) : CW'(tCL - 2);
                    end else begin
                        state_d = DATA;
                        cnt_d   = CW'(BL - 1);
                    end
                end
            end
            LAT: begin
                if (cnt == '0) begin
                    state_d = DATA;
                    cnt_d   = CW'(BL - 1);
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            DATA: begin
                if (cap_we) begin
                    dq_oe_d = 1'b1;
                    dq_o_d  = cap_wdata;
                end else begin
                    smp_v_d = 1'b1;
                end
                if (cnt == '0) state_d = PRE;
                else           cnt_d   = cnt - CW'(1);
            end
            PRE: begin
                if (!stall) begin
                    cs_n_d  = 1'b0;
                    a_d     = a_pre;
                    bg_d    = cap_bg;
                    ba_d    = cap_ba;
                    state_d = TRP;
                    cnt_d   = CW'(tRP);
                end
            end
            TRP: begin
                // tRP DES cycles, then one more edge to land in IDLE.
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cke       <= 1'b0;
            cs_n      <= 1'b1;
            act_n     <= 1'b1;
            A         <= '0;
            bg        <= '0;
            ba        <= '0;
            dq_oe     <= 1'b0;
            dq_o      <= '0;
            smp_v     <= 1'b0;
            smp_d     <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            cap_we    <= 1'b0;
            cap_bg    <= '0;
            cap_ba    <= '0;
            cap_row   <= '0;
            cap_col   <= '0;
            cap_wdata <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cke      <= 1'b1;
            cs_n     <= cs_n_d;
            act_n    <= act_n_d;
            A        <= a_d;
            bg       <= bg_d;
            ba       <= ba_d;
            dq_oe    <= dq_oe_d;
            dq_o     <= dq_o_d;
            smp_v    <= smp_v_d;
            smp_d    <= dq_i;
            rd_valid <= smp_v;
            if (smp_v) rd_data <= smp_d;
            if (capture) begin
                cap_we    <= req_we;
                cap_bg    <= req_bg;
                cap_ba    <= req_ba;
                cap_row   <= req_row;
                cap_col   <= req_col;
                cap_wdata <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// tb/tb_ddr4_cmd_issuer.sv - directed self-checking bench for ddr4_cmd_issuer
module tb_ddr4_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we;
    logic [1:0]  req_bg, req_ba;
    logic [16:0] req_row;
    logic [9:0]  req_col;
    logic [63:0] req_wdata;
    logic        cke, cs_n, act_n;
    logic [16:0] A;
    logic [1:0]  bg, ba;
    logic [63:0] dq_o, dq_i, rd_data;
    logic        dq_oe, stall, rd_valid, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    ddr4_cmd_issuer dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .req_wdata(req_wdata),
        .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
        .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i), .stall(stall),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(int n);
        return {32'hA5A5_5A5A, 32'(n * 7 + 1)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, lets it be accepted on the next edge (T), then scrambles the fields.
    task automatic send_req(input logic we, input logic [1:0] b_g, input logic [1:0] b_a,
                            input logic [16:0] row, input logic [9:0] col, input logic [63:0] wd);
        req_we = we; req_bg = b_g; req_ba = b_a; req_row = row; req_col = col; req_wdata = wd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_we = ~we; req_bg = ~b_g; req_ba = ~b_a; req_row = ~row; req_col = ~col; req_wdata = ~wd;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step(); step();
        n_cmp++;
        if ({cs_n, act_n, A, bg, ba} !== {2'b11, 21'h0}) begin
            n_fail++; $display("FAIL reset_cmd got=%h want=%h", {cs_n, act_n, A, bg, ba}, {2'b11, 21'h0});
        end
        n_cmp++;
        if ({dq_oe, dq_o, rd_valid, rd_data, req_ready, cke, busy} !== {1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL reset_misc dq_oe=%b dq_o=%h rd_valid=%b rd_data=%h req_ready=%b cke=%b busy=%b", dq_oe, dq_o, rd_valid, rd_data, req_ready, cke, busy);
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if ({cke, req_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_release_pre cke=%b req_ready=%b want 0 0", cke, req_ready);
        end
        step();
        n_cmp++;
        if ({cke, req_ready, busy} !== 3'b110) begin
            n_fail++; $display("FAIL reset_release_edge cke=%b req_ready=%b busy=%b want 1 1 0", cke, req_ready, busy);
        end
    endtask

    task automatic test_read();
        logic [22:0] want, got;
        logic        full;
        int          pulses = 0;
        send_req(1'b0, 2'd1, 2'd2, 17'h01234, 10'h03A, 64'h0);
        for (int k = 1; k <= 19; k++) begin
            stall = 1'b0;
            step();
            want = {2'b11, 21'h0}; full = 1'b0;
            if (k == 1)  begin want = {1'b0, 1'b0, 17'h01234, 2'd1, 2'd2}; full = 1'b1; end
            if (k == 4)  begin want = {1'b0, 1'b1, 17'h1403A, 2'd1, 2'd2}; full = 1'b1; end
            if (k == 16) begin want = {1'b0, 1'b1, 17'h08000, 2'd1, 2'd2}; full = 1'b1; end
            got = {cs_n, act_n, A, bg, ba};
            n_cmp++;
            if (full ? (got !== want) : (got[22:21] !== 2'b11)) begin
                n_fail++; $display("FAIL read_cmd k=%0d got=%h want=%h", k, got, want);
            end
            n_cmp++;
            if (rd_valid !== (k >= 9 && k <= 16)) begin
                n_fail++; $display("FAIL read_valid k=%0d got=%b want=%b", k, rd_valid, (k >= 9 && k <= 16));
            end
            if (rd_valid === 1'b1) pulses++;
            if (k >= 9 && k <= 16) begin
                n_cmp++;
                if (rd_data !== pat(k - 1)) begin
                    n_fail++; $display("FAIL read_data k=%0d got=%h want=%h", k, rd_data, pat(k - 1));
                end
            end
            n_cmp++;
            if ({dq_oe, dq_o, req_ready, busy} !== {1'b0, 64'h0, (k == 19), (k != 19)}) begin
                n_fail++; $display("FAIL read_status k=%0d dq_oe=%b dq_o=%h req_ready=%b busy=%b", k, dq_oe, dq_o, req_ready, busy);
            end
            dq_i = pat(k + 1);
        end
        n_cmp++;
        if (pulses != 8) begin
            n_fail++; $display("FAIL read_pulses got=%0d want=8", pulses);
        end
    endtask

    task automatic test_write();
        logic [22:0] want, got;
        logic        full;
        send_req(1'b1, 2'd2, 2'd3, 17'h0F0F0, 10'h155, 64'hDEADBEEF_CAFEF00D);
        for (int k = 1; k <= 18; k++) begin
            stall = 1'b0;
            step();
            want = {2'b11, 21'h0}; full = 1'b0;
            if (k == 1)  begin want = {1'b0, 1'b0, 17'h0F0F0, 2'd2, 2'd3}; full = 1'b1; end
            if (k == 4)  begin want = {1'b0, 1'b1, 17'h10155, 2'd2, 2'd3}; full = 1'b1; end
            if (k == 15) begin want = {1'b0, 1'b1, 17'h08000, 2'd2, 2'd3}; full = 1'b1; end
            got = {cs_n, act_n, A, bg, ba};
            n_cmp++;
            if (full ? (got !== want) : (got[22:21] !== 2'b11)) begin
                n_fail++; $display("FAIL write_cmd k=%0d got=%h want=%h", k, got, want);
            end
            n_cmp++;
            if ({dq_oe, dq_o} !== ((k >= 7 && k <= 14) ? {1'b1, 64'hDEADBEEF_CAFEF00D} : 65'h0)) begin
                n_fail++; $display("FAIL write_dq k=%0d dq_oe=%b dq_o=%h", k, dq_oe, dq_o);
            end
            n_cmp++;
            if ({rd_valid, req_ready} !== {1'b0, (k == 18)}) begin
                n_fail++; $display("FAIL write_status k=%0d rd_valid=%b req_ready=%b want 0 %b", k, rd_valid, req_ready, (k == 18));
            end
        end
    endtask

    task automatic test_stall_cmd();
        logic [22:0] want, got;
        logic        full;
        int          pulses = 0;
        send_req(1'b0, 2'd0, 2'd3, 17'h15A5A, 10'h3FF, 64'h0);
        for (int k = 1; k <= 22; k++) begin
            stall = (k >= 1 && k <= 3);
            step();
            want = {2'b11, 21'h0}; full = 1'b0;
            if (k == 4)  begin want = {1'b0, 1'b0, 17'h15A5A, 2'd0, 2'd3}; full = 1'b1; end
            if (k == 7)  begin want = {1'b0, 1'b1, 17'h143FF, 2'd0, 2'd3}; full = 1'b1; end
            if (k == 19) begin want = {1'b0, 1'b1, 17'h08000, 2'd0, 2'd3}; full = 1'b1; end
            got = {cs_n, act_n, A, bg, ba};
            n_cmp++;
            if (full ? (got !== want) : (got[22:21] !== 2'b11)) begin
                n_fail++; $display("FAIL stall_cmd k=%0d got=%h want=%h", k, got, want);
            end
            n_cmp++;
            if (rd_valid !== (k >= 12 && k <= 19)) begin
                n_fail++; $display("FAIL stall_valid k=%0d got=%b want=%b", k, rd_valid, (k >= 12 && k <= 19));
            end
            if (rd_valid === 1'b1) pulses++;
            if (k >= 12 && k <= 19) begin
                n_cmp++;
                if (rd_data !== pat(k - 1)) begin
                    n_fail++; $display("FAIL stall_data k=%0d got=%h want=%h", k, rd_data, pat(k - 1));
                end
            end
            n_cmp++;
            if (req_ready !== (k == 22)) begin
                n_fail++; $display("FAIL stall_ready k=%0d got=%b want=%b", k, req_ready, (k == 22));
            end
            dq_i = pat(k + 1);
        end
        stall = 1'b0;
        n_cmp++;
        if (pulses != 8) begin
            n_fail++; $display("FAIL stall_pulses got=%0d want=8", pulses);
        end
    endtask

    task automatic test_stall_data();
        logic [22:0] want, got;
        logic        full;
        send_req(1'b1, 2'd3, 2'd1, 17'h1ABCD, 10'h2C4, 64'h5555AAAA_12348765);
        for (int k = 1; k <= 19; k++) begin
            stall = (k >= 10 && k <= 15);
            step();
            want = {2'b11, 21'h0}; full = 1'b0;
            if (k == 1)  begin want = {1'b0, 1'b0, 17'h1ABCD, 2'd3, 2'd1}; full = 1'b1; end
            if (k == 4)  begin want = {1'b0, 1'b1, 17'h102C4, 2'd3, 2'd1}; full = 1'b1; end
            if (k == 16) begin want = {1'b0, 1'b1, 17'h08000, 2'd3, 2'd1}; full = 1'b1; end
            got = {cs_n, act_n, A, bg, ba};
            n_cmp++;
            if (full ? (got !== want) : (got[22:21] !== 2'b11)) begin
                n_fail++; $display("FAIL sdata_cmd k=%0d got=%h want=%h", k, got, want);
            end
            n_cmp++;
            if ({dq_oe, dq_o} !== ((k >= 7 && k <= 14) ? {1'b1, 64'h5555AAAA_12348765} : 65'h0)) begin
                n_fail++; $display("FAIL sdata_dq k=%0d dq_oe=%b dq_o=%h", k, dq_oe, dq_o);
            end
            n_cmp++;
            if (req_ready !== (k == 19)) begin
                n_fail++; $display("FAIL sdata_ready k=%0d got=%b want=%b", k, req_ready, (k == 19));
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        send_req(1'b0, 2'd1, 2'd1, 17'h00777, 10'h010, 64'h0);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (rd_valid === 1'b1) pulses++;
            dq_i = pat(k + 1);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd_valid, cs_n, act_n, req_ready, dq_oe} !== 5'b01100) begin
            n_fail++; $display("FAIL abort_rd_now rd_valid=%b cs_n=%b act_n=%b req_ready=%b dq_oe=%b", rd_valid, cs_n, act_n, req_ready, dq_oe);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (rd_valid === 1'b1) pulses++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (rd_valid === 1'b1) pulses++;
            n_cmp++;
            if ({cs_n, req_ready, cke} !== 3'b111) begin
                n_fail++; $display("FAIL abort_rd_after k=%0d cs_n=%b req_ready=%b cke=%b want 1 1 1", k, cs_n, req_ready, cke);
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_fail++; $display("FAIL abort_rd_pulses got=%0d want=2", pulses);
        end
        send_req(1'b1, 2'd0, 2'd0, 17'h00100, 10'h020, 64'hFEED_FACE_0BAD_F00D);
        for (int k = 1; k <= 8; k++) step();
        n_cmp++;
        if ({dq_oe, dq_o} !== {1'b1, 64'hFEED_FACE_0BAD_F00D}) begin
            n_fail++; $display("FAIL abort_wr_pre dq_oe=%b dq_o=%h want 1 feedface0badf00d", dq_oe, dq_o);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({dq_oe, dq_o, cs_n} !== {1'b0, 64'h0, 1'b1}) begin
            n_fail++; $display("FAIL abort_wr_now dq_oe=%b dq_o=%h cs_n=%b want 0 0 1", dq_oe, dq_o, cs_n);
        end
        step();
        reset_n = 1'b1;
        step();
        n_cmp++;
        if ({req_ready, cke, dq_oe} !== 3'b110) begin
            n_fail++; $display("FAIL abort_wr_after req_ready=%b cke=%b dq_oe=%b want 1 1 0", req_ready, cke, dq_oe);
        end
    endtask

    task automatic test_back_to_back();
        logic [22:0] want, got;
        logic        full;
        int          wait_cnt = 0;
        req_we = 1'b1; req_bg = 2'd0; req_ba = 2'd1; req_row = 17'h00AAA; req_col = 10'h155;
        req_wdata = 64'h01234567_89ABCDEF; req_valid = 1'b1;
        step();
        req_we = 1'b0; req_bg = 2'd3; req_ba = 2'd0; req_row = 17'h1F00F; req_col = 10'h001;
        req_wdata = 64'h0;
        for (int k = 1; k <= 20; k++) begin
            step();
            want = {2'b11, 21'h0}; full = 1'b0;
            if (k == 1)  begin want = {1'b0, 1'b0, 17'h00AAA, 2'd0, 2'd1}; full = 1'b1; end
            if (k == 4)  begin want = {1'b0, 1'b1, 17'h10155, 2'd0, 2'd1}; full = 1'b1; end
            if (k == 15) begin want = {1'b0, 1'b1, 17'h08000, 2'd0, 2'd1}; full = 1'b1; end
            if (k == 20) begin want = {1'b0, 1'b0, 17'h1F00F, 2'd3, 2'd0}; full = 1'b1; end
            got = {cs_n, act_n, A, bg, ba};
            n_cmp++;
            if (full ? (got !== want) : (got[22:21] !== 2'b11)) begin
                n_fail++; $display("FAIL b2b_cmd k=%0d got=%h want=%h", k, got, want);
            end
            n_cmp++;
            if ({dq_oe, dq_o} !== ((k >= 7 && k <= 14) ? {1'b1, 64'h01234567_89ABCDEF} : 65'h0)) begin
                n_fail++; $display("FAIL b2b_dq k=%0d dq_oe=%b dq_o=%h", k, dq_oe, dq_o);
            end
            n_cmp++;
            if (req_ready !== (k == 18)) begin
                n_fail++; $display("FAIL b2b_ready k=%0d got=%b want=%b", k, req_ready, (k == 18));
            end
            if (k == 19) req_valid = 1'b0;
        end
        while (req_ready !== 1'b1 && wait_cnt < 40) begin
            step();
            wait_cnt++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_drain req_ready=%b after %0d cycles want 1", req_ready, wait_cnt);
        end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_bg = '0; req_ba = '0;
        req_row = '0; req_col = '0; req_wdata = '0; dq_i = '0; stall = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_stall_cmd();
        test_stall_data();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
